uart_tx_arbiter: RTL

Shares the single UART transmitter among `NUM_REQ` byte sources (e.g. CPU register writes, boot loader, debug monitor) by round-robin arbitration. It accepts one byte per valid/ready handshake and drives the transmitter's `tx_en`, `begin_flag` and `tx_data`. It then tracks `busy_flag` until the frame is finished. It sits between the requesters and the `tx` sub-block of the UART, replacing the direct CPU-to-`tx` wiring.

---
 rtl/uart_ctrl_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbitration path.
// The FSM encoding is fixed so that the debug state output can be decoded directly.
package uart_ctrl_pkg;

    localparam int UART_DATA_W = 8;
    localparam int SENT_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last grant.
// It returns a one-hot grant, the index of the winner, and whether anyone won.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int GRANT_W = grant_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last,
    output logic [NUM_REQ-1:0] grant,
    output logic [GRANT_W-1:0] grant_idx,
    output logic               grant_valid
);

    always_comb begin
        int               idx;
        logic [GRANT_W-1:0] pos;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        pos         = '0;
        // k runs 1..NUM_REQ so that the last winner is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            pos = GRANT_W'(idx);
            if (!grant_valid && req[pos]) begin
                grant_valid = 1'b1;
                grant[pos]  = 1'b1;
                grant_idx   = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end for the shared UART transmitter: grants one byte at a time,
// pulses the transmitter start, then follows busy_flag until the frame completes.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter  int NUM_REQ       = 2,
    parameter  int START_TIMEOUT = 8,
    localparam int GRANT_W       = grant_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           busy_flag,
    output logic                           tx_en,
    output logic                           begin_flag,
    output logic [UART_DATA_W-1:0]         tx_data,
    output logic [GRANT_W-1:0]             grant_id,
    output logic                           done,
    output logic                           err_timeout,
    output logic [SENT_CNT_W-1:0]          sent_count,
    output logic [1:0]                     fsm_state
);

    localparam int TMO_W = $clog2(START_TIMEOUT + 1);

    tx_state_t          state, state_next;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_next;
    logic [NUM_REQ-1:0] arb_grant;
    logic [GRANT_W-1:0] arb_idx;
    logic               arb_valid;
    logic               do_grant;
    logic               done_next;
    logic               tmo_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req         (req_valid),
        .last        (grant_id),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Handshake: a byte is taken at the clock edge where req_valid[i] & req_ready[i];
    // ready is offered only in IDLE, only while enabled and out of reset, and is one-hot.
    assign req_ready = do_grant ? arb_grant : '0;
    assign tx_en     = enable;
    assign fsm_state = state;

    always_comb begin
        state_next   = state;
        tmo_cnt_next = tmo_cnt;
        do_grant     = 1'b0;
        done_next    = 1'b0;
        tmo_next     = 1'b0;
        case (state)
            IDLE: begin
                if (reset && enable && arb_valid) begin
                    do_grant   = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tmo_cnt_next = '0;
                state_next   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_flag) begin
                    state_next = WAIT_DONE;
                end else begin
                    tmo_cnt_next = tmo_cnt + 1'b1;
                    // The byte is abandoned; the requester already saw its handshake.
                    if (tmo_cnt_next == TMO_W'(START_TIMEOUT)) begin
                        tmo_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!busy_flag) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            begin_flag  <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            tx_data     <= '0;
            grant_id    <= GRANT_W'(NUM_REQ - 1);
            sent_count  <= '0;
        end else begin
            state       <= state_next;
            tmo_cnt     <= tmo_cnt_next;
            begin_flag  <= do_grant;
            done        <= done_next;
            err_timeout <= tmo_next;
            if (do_grant) begin
                tx_data  <= req_data[{arb_idx, 3'b000} +: UART_DATA_W];
                grant_id <= arb_idx;
            end
            if (done_next) begin
                sent_count <= sent_count + 1'b1;
            end
        end
    end

endmodule
